// File: rtl/shift_chain_ctrl.sv
// rtl/shift_chain_ctrl.sv - load/shift chain sequencer with valid/ready word in and captured word out
module shift_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s_in,
    output logic             s_out,
    output logic             select,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Index of the final shift; the counter parks here instead of wrapping.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] chain;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] chain_next;

    // Next chain value during a shift: MSB leaves on s_out, s_in enters at the LSB.
    assign chain_next = {chain[WIDTH-2:0], s_in};

    // Handshake and stage-control outputs decode straight from the state register.
    assign in_ready  = (state == ST_IDLE);
    assign select    = (state == ST_SHIFT);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign s_out     = chain[WIDTH-1];

    // Sequencer: load in IDLE, shift WIDTH edges, then hold the captured word until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            chain    <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        chain <= in_data;
                        count <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    chain <= chain_next;
                    if (count == LAST_SHIFT) begin
                        out_data <= chain_next;
                        state    <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
